// File: rtl/alu_sequencer.sv
// alu_sequencer: sequences one alu_with_reg datapath through the
// load A / load B / execute / transfer cycles for a single operand-pair
// request and returns the result as a one-cycle response strobe.
// Optional feature macro: ALU_SEQ_CHAIN_EN. When it is defined, a chained
// request reuses the previous result held in datapath register A.
module alu_sequencer #(
  parameter int BIT_WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_op,
  input  logic                 req_chain,
  input  logic [BIT_WIDTH-1:0] req_a,
  input  logic [BIT_WIDTH-1:0] req_b,
  output logic                 rsp_valid,
  output logic [BIT_WIDTH-1:0] rsp_data,
  output logic                 rsp_carry,
  output logic [BIT_WIDTH-1:0] dp_in,
  output logic [1:0]           dp_reg_addr,
  output logic                 dp_s_reg,
  output logic                 dp_s,
  input  logic [BIT_WIDTH-1:0] dp_out,
  input  logic                 dp_cout
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LD_A = 3'd1,
    ST_LD_B = 3'd2,
    ST_EXEC = 3'd3,
    ST_XFER = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  // Datapath register-select codes
  localparam logic [1:0] ADDR_A    = 2'd0;
  localparam logic [1:0] ADDR_B    = 2'd1;
  localparam logic [1:0] ADDR_OUT  = 2'd2;
  localparam logic [1:0] ADDR_NONE = 2'd3;

  state_t                 state_r;
  state_t                 state_next_s;
  logic                   op_r;
  logic [BIT_WIDTH-1:0]   a_r;
  logic [BIT_WIDTH-1:0]   b_r;
  logic                   rsp_carry_r;
  logic                   accept_s;
  logic                   skip_a_s;

  assign accept_s = req_valid && (state_r == ST_IDLE);

`ifdef ALU_SEQ_CHAIN_EN
  logic a_valid_r;

  assign skip_a_s = req_chain && a_valid_r;

  // Register A holds a usable previous result once any op has executed
  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid_r <= 1'b0;
    end else if (state_r == ST_EXEC) begin
      a_valid_r <= 1'b1;
    end
  end
`else
  logic chain_unused_s;

  assign chain_unused_s = req_chain;
  assign skip_a_s       = 1'b0;
`endif

  // State register; reset aborts any op in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Operand capture at the accepting edge
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r <= 1'b0;
      a_r  <= '0;
      b_r  <= '0;
    end else if (accept_s) begin
      op_r <= req_op;
      a_r  <= req_a;
      b_r  <= req_b;
    end
  end

  // Carry of the executed op, still visible on dp_cout during XFER
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_carry_r <= 1'b0;
    end else if (state_r == ST_XFER) begin
      rsp_carry_r <= dp_cout;
    end
  end

  // Next-state sequencing
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (skip_a_s) begin
            state_next_s = ST_LD_B;
          end else begin
            state_next_s = ST_LD_A;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LD_A: state_next_s = ST_LD_B;
      ST_LD_B: state_next_s = ST_EXEC;
      ST_EXEC: state_next_s = ST_XFER;
      ST_XFER: state_next_s = ST_DONE;
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Moore decode of datapath controls and handshake from registered state
  always_comb begin
    dp_reg_addr = ADDR_NONE;
    dp_s_reg    = 1'b0;
    dp_s        = 1'b0;
    dp_in       = '0;
    rsp_valid   = 1'b0;
    req_ready   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        req_ready = 1'b1;
      end
      ST_LD_A: begin
        dp_reg_addr = ADDR_A;
        dp_s_reg    = 1'b1;
        dp_in       = a_r;
      end
      ST_LD_B: begin
        dp_reg_addr = ADDR_B;
        dp_s_reg    = 1'b1;
        dp_in       = b_r;
      end
      ST_EXEC: begin
        dp_reg_addr = ADDR_A;
        dp_s        = op_r;
      end
      ST_XFER: begin
        dp_reg_addr = ADDR_OUT;
      end
      ST_DONE: begin
        rsp_valid = 1'b1;
      end
      default: begin
        dp_reg_addr = ADDR_NONE;
      end
    endcase
  end

  assign rsp_data  = dp_out;
  assign rsp_carry = rsp_carry_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer (BIT_WIDTH=8) with a behavioural
// alu_with_reg stand-in (op 0 = add, op 1 = subtract) and an arithmetic
// reference model. Honours ALU_SEQ_CHAIN_EN when defined.
module tb_alu_sequencer;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_op;
  logic       req_chain;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_carry;
  logic [7:0] dp_in;
  logic [1:0] dp_reg_addr;
  logic       dp_s_reg;
  logic       dp_s;
  logic [7:0] dp_out;
  logic       dp_cout;

  int n_checks = 0;
  int n_fail   = 0;

  alu_sequencer #(.BIT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_chain(req_chain), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_carry(rsp_carry),
    .dp_in(dp_in), .dp_reg_addr(dp_reg_addr), .dp_s_reg(dp_s_reg),
    .dp_s(dp_s), .dp_out(dp_out), .dp_cout(dp_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath stand-in: registers A, B, out and a carry register (no reset)
  logic [7:0] dpa, dpb, dpo;
  logic       dpc;
  logic [8:0] alu_s;
  always_comb alu_s = dp_s ? ({1'b0, dpa} + {1'b0, ~dpb} + 9'd1)
                           : ({1'b0, dpa} + {1'b0, dpb});
  always @(posedge clk) begin
    case (dp_reg_addr)
      2'd0: dpa <= dp_s_reg ? dp_in : alu_s[7:0];
      2'd1: dpb <= dp_s_reg ? dp_in : alu_s[7:0];
      2'd2: dpo <= dpa;
      default: ;
    endcase
    dpc <= alu_s[8];
  end
  assign dp_out  = dpo;
  assign dp_cout = dpc;

  // Reference model state: last result left in register A and its validity
  logic [7:0] prev_res;
  logic       prev_valid = 1'b0;

  // Per-op observation and expectation
  logic [1:0] tr_addr  [1:6];
  logic       tr_s     [1:6];
  logic       tr_sreg  [1:6];
  logic       tr_valid [1:6];
  logic       tr_ready [1:6];
  logic [7:0] tr_in    [1:6];
  logic [7:0] tr_data  [1:6];
  logic       tr_carry [1:6];
  logic       acc_ready;
  logic       exp_chain;
  logic [7:0] exp_res;
  logic       exp_carry;

  // Position in the full six-step sequence (chained ops start at LD_B)
  function automatic int seq_pos(input logic chained, input int k);
    return chained ? k + 1 : k;
  endfunction

  function automatic logic [1:0] exp_addr(input logic chained, input int k);
    case (seq_pos(chained, k))
      1: return 2'd0;
      2: return 2'd1;
      3: return 2'd0;
      4: return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic [7:0] exp_in(input logic chained, input int k,
                                        input logic [7:0] a, input logic [7:0] b);
    case (seq_pos(chained, k))
      1: return a;
      2: return b;
      default: return 8'h00;
    endcase
  endfunction

  // Drive one request, record six cycles after the accept, update model
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic op, input logic chain, input logic hold);
    logic [7:0] opa;
    int s;
`ifdef ALU_SEQ_CHAIN_EN
    exp_chain = chain && prev_valid;
`else
    exp_chain = 1'b0;
`endif
    opa = exp_chain ? prev_res : a;
    if (op == 1'b0) begin
      s = int'(opa) + int'(b);
      exp_carry = (s > 255);
    end else begin
      s = int'(opa) - int'(b);
      exp_carry = (opa >= b);
    end
    exp_res = 8'(s & 255);
    prev_res = exp_res;
    prev_valid = 1'b1;

    @(negedge clk);
    req_valid = 1'b1; req_a = a; req_b = b; req_op = op; req_chain = chain;
    acc_ready = req_ready;
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
    req_a = 8'($urandom); req_b = 8'($urandom); req_op = 1'($urandom);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      tr_addr[k] = dp_reg_addr; tr_s[k] = dp_s; tr_sreg[k] = dp_s_reg;
      tr_valid[k] = rsp_valid; tr_ready[k] = req_ready; tr_in[k] = dp_in;
      tr_data[k] = rsp_data; tr_carry[k] = rsp_carry;
      if (hold && k == 5) req_valid = 1'b0;
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || dp_reg_addr !== 2'd3 ||
          dp_s_reg !== 1'b0 || dp_s !== 1'b0 || dp_in !== 8'h00 || rsp_carry !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_in cyc=%0d got rdy=%b vld=%b addr=%0d sreg=%b s=%b in=%h c=%b want 1 0 3 0 0 00 0",
                 i, req_ready, rsp_valid, dp_reg_addr, dp_s_reg, dp_s, dp_in, rsp_carry);
      end
    end
    rst = 1'b0;
    prev_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || dp_reg_addr !== 2'd3) begin
        n_fail++;
        $display("FAIL reset_idle cyc=%0d got rdy=%b vld=%b addr=%0d want 1 0 3",
                 i, req_ready, rsp_valid, dp_reg_addr);
      end
    end
  endtask

  task automatic test_add;
    run_op(8'h12, 8'h34, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (acc_ready !== 1'b1) begin
      n_fail++; $display("FAIL add_ready got %b want 1", acc_ready);
    end
    for (int k = 1; k <= 5; k++) begin
      n_checks++;
      if (tr_addr[k] !== exp_addr(1'b0, k) || tr_valid[k] !== (k == 5)) begin
        n_fail++;
        $display("FAIL add_seq k=%0d got addr=%0d vld=%b want addr=%0d vld=%b",
                 k, tr_addr[k], tr_valid[k], exp_addr(1'b0, k), (k == 5));
      end
    end
    n_checks++;
    if (tr_data[5] !== 8'h46 || tr_carry[5] !== 1'b0) begin
      n_fail++;
      $display("FAIL add_result got %h/%b want 46/0", tr_data[5], tr_carry[5]);
    end
  endtask

  task automatic test_carry;
    run_op(8'hF0, 8'h20, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (tr_data[5] !== 8'h10 || tr_carry[5] !== 1'b1) begin
      n_fail++;
      $display("FAIL carry_result got %h/%b want 10/1", tr_data[5], tr_carry[5]);
    end
    n_checks++;
    if (tr_s[3] !== 1'b0) begin
      n_fail++; $display("FAIL carry_exec_s got %b want 0", tr_s[3]);
    end
    n_checks++;
    if (tr_data[6] !== 8'h10 || tr_carry[6] !== 1'b1) begin
      n_fail++;
      $display("FAIL carry_hold got %h/%b want 10/1", tr_data[6], tr_carry[6]);
    end
  endtask

  task automatic test_op1_hold;
    run_op(8'h5A, 8'h3C, 1'b1, 1'b0, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      n_checks++;
      if (tr_s[k] !== (k == 3) || tr_ready[k] !== (k == 6)) begin
        n_fail++;
        $display("FAIL op1_hold k=%0d got s=%b rdy=%b want s=%b rdy=%b",
                 k, tr_s[k], tr_ready[k], (k == 3), (k == 6));
      end
    end
    n_checks++;
    if (tr_addr[6] !== 2'd3 || tr_data[5] !== exp_res || tr_carry[5] !== exp_carry) begin
      n_fail++;
      $display("FAIL op1_result got addr6=%0d %h/%b want 3 %h/%b",
               tr_addr[6], tr_data[5], tr_carry[5], exp_res, exp_carry);
    end
  endtask

  task automatic test_random;
    logic [7:0] a, b;
    logic op, ch;
    for (int n = 0; n < 24; n++) begin
      a = 8'($urandom); b = 8'($urandom); op = 1'($urandom); ch = 1'($urandom);
      run_op(a, b, op, ch, 1'b0);
      for (int k = 1; k <= 6; k++) begin
        n_checks++;
        if (tr_addr[k] !== exp_addr(exp_chain, k) ||
            tr_in[k] !== exp_in(exp_chain, k, a, b) ||
            tr_sreg[k] !== (seq_pos(exp_chain, k) <= 2) ||
            tr_s[k] !== (seq_pos(exp_chain, k) == 3 ? op : 1'b0) ||
            tr_valid[k] !== (seq_pos(exp_chain, k) == 5) ||
            tr_ready[k] !== (seq_pos(exp_chain, k) >= 6)) begin
          n_fail++;
          $display("FAIL rand_trace n=%0d k=%0d got addr=%0d in=%h sreg=%b s=%b vld=%b rdy=%b want addr=%0d in=%h chain=%b op=%b",
                   n, k, tr_addr[k], tr_in[k], tr_sreg[k], tr_s[k], tr_valid[k], tr_ready[k],
                   exp_addr(exp_chain, k), exp_in(exp_chain, k, a, b), exp_chain, op);
        end
      end
      n_checks++;
      if (tr_data[exp_chain ? 4 : 5] !== exp_res || tr_carry[exp_chain ? 4 : 5] !== exp_carry) begin
        n_fail++;
        $display("FAIL rand_result n=%0d got %h/%b want %h/%b",
                 n, tr_data[exp_chain ? 4 : 5], tr_carry[exp_chain ? 4 : 5], exp_res, exp_carry);
      end
    end
  endtask

  task automatic test_chain;
    run_op(8'h05, 8'h03, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (tr_data[5] !== 8'h08) begin
      n_fail++; $display("FAIL chain_first got %h want 08", tr_data[5]);
    end
    run_op(8'hFF, 8'h02, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (tr_addr[1] !== exp_addr(exp_chain, 1) || tr_valid[4] !== exp_chain ||
        tr_valid[5] !== !exp_chain) begin
      n_fail++;
      $display("FAIL chain_timing got addr1=%0d v4=%b v5=%b want addr1=%0d v4=%b",
               tr_addr[1], tr_valid[4], tr_valid[5], exp_addr(exp_chain, 1), exp_chain);
    end
    n_checks++;
    if (tr_data[exp_chain ? 4 : 5] !== exp_res) begin
      n_fail++;
      $display("FAIL chain_result got %h want %h", tr_data[exp_chain ? 4 : 5], exp_res);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; prev_valid = 1'b0;
    run_op(8'h11, 8'h22, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (tr_addr[1] !== 2'd0 || tr_in[1] !== 8'h11 || tr_valid[5] !== 1'b1 || tr_data[5] !== 8'h33) begin
      n_fail++;
      $display("FAIL chain_after_reset got addr1=%0d in1=%h v5=%b data=%h want 0 11 1 33",
               tr_addr[1], tr_in[1], tr_valid[5], tr_data[5]);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    req_valid = 1'b1; req_a = 8'h40; req_b = 8'h07; req_op = 1'b0; req_chain = 1'b0;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (dp_reg_addr !== 2'd0 || dp_s_reg !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_exec got addr=%0d sreg=%b want 0 0", dp_reg_addr, dp_s_reg);
    end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    prev_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || dp_reg_addr !== 2'd3) begin
        n_fail++;
        $display("FAIL mid_abort cyc=%0d got vld=%b rdy=%b addr=%0d want 0 1 3",
                 i, rsp_valid, req_ready, dp_reg_addr);
      end
    end
    run_op(8'h21, 8'h10, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (tr_addr[1] !== 2'd0 || tr_valid[5] !== 1'b1 || tr_data[5] !== 8'h31) begin
      n_fail++;
      $display("FAIL mid_rerun got addr1=%0d v5=%b data=%h want 0 1 31",
               tr_addr[1], tr_valid[5], tr_data[5]);
    end
  endtask

  task automatic test_reset_accept;
    @(negedge clk);
    req_valid = 1'b1; req_a = 8'h01; req_b = 8'h01; req_op = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0; prev_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || dp_reg_addr !== 2'd3) begin
        n_fail++;
        $display("FAIL rst_accept cyc=%0d got vld=%b rdy=%b addr=%0d want 0 1 3",
                 i, rsp_valid, req_ready, dp_reg_addr);
      end
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_chain = 1'b0;
    req_a = 8'h00; req_b = 8'h00;
    test_reset;
    test_add;
    test_carry;
    test_op1_hold;
    test_random;
    test_chain;
    test_reset_mid;
    test_reset_accept;
    test_add;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Controller that sequences one `alu_with_reg` datapath instance, turning a single operand-pair request into the register-load / execute / transfer cycle sequence. It accepts requests through a valid/ready handshake and drives the datapath's `in`, `reg_addr`, `s_reg` and `s` inputs. It returns the result from the datapath's `out` and `cout` as a one-cycle response pulse. It sits between the instruction/control layer and the datapath.

## Interface
- `BIT_WIDTH`, 1, operand/result width; must match the datapath instance.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept; high only in IDLE.
- `req_op`  in  1  ALU operation select, forwarded to `dp_s` during EXEC.
- `req_chain`  in  1  use previous result as operand A (see Configuration).
- `req_a`, `req_b`  in  BIT_WIDTH  operands.
- `rsp_valid`  out  1  one-cycle result strobe.
- `rsp_data`  out  BIT_WIDTH  result; wired from `dp_out`.
- `rsp_carry`  out  1  carry of the executed op.
- `dp_in`  out  BIT_WIDTH  to datapath `in`.
- `dp_reg_addr`  out  2  to datapath `reg_addr`: 0 = load A, 1 = load B, 2 = load output, 3 = no load.
- `dp_s_reg`  out  1  to datapath `s_reg`: 1 = external input, 0 = ALU result.
- `dp_s`  out  1  to datapath `s`.
- `dp_out`  in  BIT_WIDTH  from datapath `out`.
- `dp_cout`  in  1  from datapath `cout` (registered carry).

## Operation
- **Handshake:**
  - A request is accepted on an edge with `req_valid && req_ready`.
  - `req_op`, `req_chain`, `req_a` and `req_b` are latched into internal registers at that edge.
- **States and transitions:**
  - IDLE → LD_A → LD_B → EXEC → XFER → DONE → IDLE.
  - With chaining active, IDLE → LD_B directly, skipping LD_A.
- **Datapath drive:** Moore outputs decoded from registered state and latched operands only; there is no combinational path from `req_*` to `dp_*`.
  - IDLE/DONE: `dp_reg_addr`=3, `dp_s_reg`=0, `dp_s`=0, `dp_in`=0.
  - LD_A: `dp_reg_addr`=0, `dp_s_reg`=1, `dp_in`=a_q.
  - LD_B: `dp_reg_addr`=1, `dp_s_reg`=1, `dp_in`=b_q.
  - EXEC: `dp_reg_addr`=0, `dp_s_reg`=0, `dp_s`=op_q; register A captures the ALU result and the datapath carry register captures that op's carry.
  - XFER: `dp_reg_addr`=2; the output register captures register A.
    - The controller samples `dp_cout` into `rsp_carry` at the XFER edge. This carry belongs to EXEC; the datapath carry register re-captures every cycle, so it is not sampled later.
  - DONE: `rsp_valid`=1 for exactly one cycle.
- **Response:**
  - No backpressure; the consumer must take the result on the `rsp_valid` cycle.
  - `rsp_data` and `rsp_carry` stay stable until the next XFER edge.
- **a_valid flag:**
  - Set at the EXEC edge; cleared by reset.
  - Marks register A as holding a valid previous result.
- **Reset:**
  - State returns to IDLE on the next edge, including mid-operation.
  - The aborted op never produces `rsp_valid`.
  - Datapath registers have no reset; their contents are undefined until loaded.

## Timing
- Reset values:
  - `req_ready`=1.
  - `rsp_valid`=0, `rsp_carry`=0.
  - `dp_reg_addr`=3, `dp_s_reg`=0, `dp_s`=0, `dp_in`=0.
  - a_valid=0.
- Accept at edge N gives `rsp_valid` high in cycle N+5 (non-chained) or N+4 (chained).
- Throughput: one op per 6 cycles (5 chained); `req_ready` is low from the edge after accept until DONE→IDLE.
- `req_valid` is ignored while `req_ready`=0; requests are not queued.
- `rst` asserted in the same cycle as an accept: reset wins, the request is dropped, and `req_ready` is 1 next cycle.

## Configuration
- Macro: `ALU_SEQ_CHAIN_EN`.
- **Defined:**
  - `req_chain`=1 with a_valid=1 skips LD_A, and operand A is the previous result held in register A; `req_a` is ignored.
  - `req_chain`=1 with a_valid=0 runs the full sequence using `req_a`.
- **Undefined:**
  - The `req_chain` port still exists but is ignored.
  - Every request runs the full sequence.
  - a_valid logic is omitted.

## Test plan
- Reset with BIT_WIDTH=8 → `req_ready`=1, `rsp_valid`=0, `dp_reg_addr`=3 every cycle until a request arrives.
- Add request a=8'h12, b=8'h34, op=0 accepted at edge N → `dp_reg_addr` sequence 0,1,0,2,3 over cycles N+1..N+5; `rsp_valid` high only at N+5 with `rsp_data`=8'h46 and `rsp_carry`=0.
- Add request a=8'hF0, b=8'h20, op=0 → `rsp_data`=8'h10, `rsp_carry`=1; `dp_s`=0 in EXEC.
- Request with op=1 → `dp_s`=1 only during EXEC; `req_valid` held high in cycles N+1..N+5 is not accepted until IDLE.
- With `ALU_SEQ_CHAIN_EN`: first op 8'h05+8'h03 gives 8'h08; then chained request with b=8'h02 and `req_a`=8'hFF → LD_A skipped, `rsp_valid` at N+4, `rsp_data`=8'h0A. A chained request directly after reset uses `req_a`.
- `rst` pulsed during EXEC → IDLE on the next edge, no `rsp_valid` pulse, `req_ready`=1; a subsequent chained request runs the full sequence.
